pipe_hazard_ctrl: RTL
=====================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16: maximum cycles MEM_WAIT holds before declaring a memory error (range 2..255).
REQ-002 SHALL have parameter REG_ADDR_W, default 5: register address width.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have ports id_rs1_addr / id_rs2_addr, input, REG_ADDR_W: source registers of the instruction in ID.
REQ-006 SHALL have ports id_rs1_used / id_rs2_used, input, 1: the ID instruction reads rs1 / rs2.
REQ-007 SHALL have port ex_rd_addr, input, REG_ADDR_W: destination register of the instruction in EX.
REQ-008 SHALL have port ex_mem_read, input, 3: EX load type; nonzero means load.
REQ-009 SHALL have port ex_redirect, input, 1: taken branch, JAL or JALR resolved in EX.
REQ-010 SHALL have port mem_req, input, 1: MEM stage holds a load or store.
REQ-011 SHALL have port dmem_ack, input, 1: data memory completes the access this cycle.
REQ-012 SHALL have outputs pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, each 1: hold the respective register.
REQ-013 SHALL have outputs if_id_flush, id_ex_flush, mem_wb_bubble, each 1: insert a NOP into the respective register.
REQ-014 SHALL have output mem_err, 1: one-cycle pulse on memory timeout.
REQ-015 SHALL have output state_o, 2: current FSM state (RUN=00, MEM_WAIT=01, ERR=10).

Function
REQ-016 SHALL implement FSM states RUN, MEM_WAIT and ERR; control outputs are combinational from state and current inputs.
REQ-017 RUN with mem_req=1 and dmem_ack=0 SHALL assert all four stalls plus mem_wb_bubble, load wait_cnt=1, and go to MEM_WAIT.
REQ-018 RUN with mem_req=1 and dmem_ack=1 SHALL NOT stall; the access completes with zero extra latency.
REQ-019 MEM_WAIT SHALL assert all four stalls plus mem_wb_bubble while dmem_ack=0, and increment wait_cnt each cycle.
REQ-020 MEM_WAIT with dmem_ack=1 SHALL deassert all stalls that cycle and return to RUN.
REQ-021 MEM_WAIT with dmem_ack=0 and wait_cnt==MEM_TIMEOUT SHALL go to ERR.
REQ-022 ERR SHALL last exactly one cycle: pulse mem_err=1, assert mem_wb_bubble, deassert stalls, return to RUN.
REQ-023 Load-use hazard in RUN SHALL exist when ex_mem_read!=0, ex_rd_addr!=0, and (id_rs1_used and id_rs1_addr==ex_rd_addr, or id_rs2_used and id_rs2_addr==ex_rd_addr).
REQ-024 On load-use hazard, pc_stall=if_id_stall=1 and id_ex_flush=1 for one cycle; no state change.
REQ-025 ex_redirect in RUN SHALL assert if_id_flush=1 and id_ex_flush=1 for that cycle; pc is not stalled.
REQ-026 Priority SHALL be memory wait > redirect > load-use; redirect with a coincident load-use SHALL flush and not stall.
REQ-027 A redirect or load-use arriving during MEM_WAIT SHALL be ignored until return to RUN; EX is frozen, so the condition re-presents.
REQ-028 x0 SHALL never cause a load-use stall.

Reset
REQ-029 rst_n=0 SHALL asynchronously force state=RUN and wait_cnt=0; all stall, flush and bubble outputs, mem_err and perf counters read 0.
REQ-030 Reset asserted mid-MEM_WAIT SHALL abandon the wait without a mem_err pulse.

Configuration
REQ-031 Macro HAZARD_PERF_CNT_EN SHALL, when defined, add outputs stall_cycles[31:0] (cycles with pc_stall=1) and flush_count[31:0] (cycles with if_id_flush=1), both saturating at 0xFFFFFFFF.
REQ-032 Without HAZARD_PERF_CNT_EN the counters and their ports SHALL not exist; all other behaviour is identical.

Verification
REQ-033 ex_mem_read=3'b010, ex_rd=5, id_rs1=5 with id_rs1_used=1 -> exactly one cycle of pc_stall=if_id_stall=id_ex_flush=1.
REQ-034 Same as REQ-033 but ex_rd=0 -> no stall.
REQ-035 mem_req=1, dmem_ack rising after 3 cycles -> 3 stall cycles, return to RUN, mem_err=0.
REQ-036 mem_req=1, dmem_ack=0 for 16 cycles -> MEM_WAIT, then ERR, mem_err single pulse, then RUN.
REQ-037 ex_redirect=1 coincident with load-use -> if_id_flush=id_ex_flush=1, pc_stall=0.
REQ-038 rst_n low in cycle 2 of MEM_WAIT -> state_o=00 immediately, all outputs 0; with HAZARD_PERF_CNT_EN, stall_cycles=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Hazard controller for a 5-stage in-order pipeline. It handles
//               three cases:
//                 - Data-memory wait states (stall everything, bubble MEM/WB).
//                 - Control redirects resolved in EX (flush IF/ID and ID/EX).
//                 - Load-use data hazards (stall PC and IF/ID, flush ID/EX).
//               When a memory access waits longer than MEM_TIMEOUT cycles,
//               the controller emits a single-cycle mem_err pulse.
// Ports       : clk, rst_n (async, active-low)
//               id_rs1_addr/id_rs2_addr, id_rs1_used/id_rs2_used : ID sources
//               ex_rd_addr, ex_mem_read, ex_redirect              : EX info
//               mem_req, dmem_ack                                 : MEM handshake
//               pc_stall, if_id_stall, id_ex_stall, ex_mem_stall  : holds
//               if_id_flush, id_ex_flush, mem_wb_bubble           : NOP inserts
//               mem_err (pulse), state_o (RUN=00, MEM_WAIT=01, ERR=10)
//               stall_cycles, flush_count (only with HAZARD_PERF_CNT_EN)
// Options     : define HAZARD_PERF_CNT_EN to add saturating perf counters
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int REG_ADDR_W  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr,
    input  logic [2:0]            ex_mem_read,
    input  logic                  ex_redirect,
    input  logic                  mem_req,
    input  logic                  dmem_ack,
    output logic                  pc_stall,
    output logic                  if_id_stall,
    output logic                  id_ex_stall,
    output logic                  ex_mem_stall,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  mem_wb_bubble,
    output logic                  mem_err,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0]           stall_cycles,
    output logic [31:0]           flush_count,
`endif
    output logic [1:0]            state_o
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_ERR      = 2'b10
    } state_t;

    localparam logic [7:0] C_TIMEOUT = 8'(MEM_TIMEOUT);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_wait_cnt;
    logic [7:0] w_wait_cnt_nxt;

    logic w_load_use;
    logic w_mem_wait;
    logic w_pc_stall, w_if_id_stall, w_id_ex_stall, w_ex_mem_stall;
    logic w_if_id_flush, w_id_ex_flush, w_mem_wb_bubble, w_mem_err;

    // x0 is hard-wired zero, so a load targeting it never creates a hazard.
    assign w_load_use = (ex_mem_read != 3'b000) && (ex_rd_addr != '0) &&
                        ((id_rs1_used && (id_rs1_addr == ex_rd_addr)) ||
                         (id_rs2_used && (id_rs2_addr == ex_rd_addr)));

    assign w_mem_wait = mem_req && !dmem_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_wait_cnt_nxt  = r_wait_cnt;
        w_pc_stall      = 1'b0;
        w_if_id_stall   = 1'b0;
        w_id_ex_stall   = 1'b0;
        w_ex_mem_stall  = 1'b0;
        w_if_id_flush   = 1'b0;
        w_id_ex_flush   = 1'b0;
        w_mem_wb_bubble = 1'b0;
        w_mem_err       = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_mem_wait) begin
                    w_pc_stall      = 1'b1;
                    w_if_id_stall   = 1'b1;
                    w_id_ex_stall   = 1'b1;
                    w_ex_mem_stall  = 1'b1;
                    w_mem_wb_bubble = 1'b1;
                    w_wait_cnt_nxt  = 8'd1;
                    w_state_nxt     = ST_MEM_WAIT;
                end else if (ex_redirect) begin
                    // A redirect squashes the dependent instruction anyway,
                    // so a coincident load-use needs no stall.
                    w_if_id_flush = 1'b1;
                    w_id_ex_flush = 1'b1;
                end else if (w_load_use) begin
                    w_pc_stall    = 1'b1;
                    w_if_id_stall = 1'b1;
                    w_id_ex_flush = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                // EX is frozen here, so any redirect/load-use re-presents
                // once the controller is back in RUN.
                if (dmem_ack) begin
                    w_state_nxt    = ST_RUN;
                    w_wait_cnt_nxt = 8'd0;
                end else begin
                    w_pc_stall      = 1'b1;
                    w_if_id_stall   = 1'b1;
                    w_id_ex_stall   = 1'b1;
                    w_ex_mem_stall  = 1'b1;
                    w_mem_wb_bubble = 1'b1;
                    if (r_wait_cnt == C_TIMEOUT) begin
                        w_state_nxt    = ST_ERR;
                        w_wait_cnt_nxt = 8'd0;
                    end else begin
                        w_wait_cnt_nxt = r_wait_cnt + 8'd1;
                    end
                end
            end
            ST_ERR: begin
                w_mem_err       = 1'b1;
                w_mem_wb_bubble = 1'b1;
                w_state_nxt     = ST_RUN;
            end
            default: begin
                w_state_nxt    = ST_RUN;
                w_wait_cnt_nxt = 8'd0;
            end
        endcase
    end

    // Outputs are forced low while reset is held, even though the FSM
    // outputs depend combinationally on live inputs.
    assign pc_stall      = w_pc_stall      & rst_n;
    assign if_id_stall   = w_if_id_stall   & rst_n;
    assign id_ex_stall   = w_id_ex_stall   & rst_n;
    assign ex_mem_stall  = w_ex_mem_stall  & rst_n;
    assign if_id_flush   = w_if_id_flush   & rst_n;
    assign id_ex_flush   = w_id_ex_flush   & rst_n;
    assign mem_wb_bubble = w_mem_wb_bubble & rst_n;
    assign mem_err       = w_mem_err       & rst_n;
    assign state_o       = r_state;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= 32'd0;
            r_flush_count  <= 32'd0;
        end else begin
            if (pc_stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (if_id_flush && (r_flush_count != 32'hFFFF_FFFF)) begin
                r_flush_count <= r_flush_count + 32'd1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;
`endif

endmodule
`default_nettype wire
